control_sequencer: RTL



---
 rtl/cpu_ctrl_pkg.sv | 48 ++++
 rtl/ctrl_decode.sv | 79 +++++++
 rtl/control_sequencer.sv | 100 ++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared opcode, control-state and strobe-bundle definitions for the hardwired control unit.
// Pure declarations: no latency, no backpressure.
package cpu_ctrl_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        RST  = 4'd0,
        F0   = 4'd1,
        F1   = 4'd2,
        F2   = 4'd3,
        E3   = 4'd4,
        E4   = 4'd5,
        E5   = 4'd6,
        E6   = 4'd7,
        E7   = 4'd8,
        HALT = 4'd9
    } state_t;

    typedef struct packed {
        logic read, write, pc_out, zlow_out, mdr_out, c_out, ba_out, r_out;
        logic mar_in, pc_in, mdr_in, ir_in, y_in, z_in, con_in, r_in;
        logic inc_pc, gra, grb, grc, alu_add, alu_sub, alu_and, alu_or, run;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

    function automatic logic is_rtype(input logic [4:0] op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR};
    endfunction

    // Opcodes that own at least one execute state after F2.
    function automatic logic has_exec(input logic [4:0] op);
        return is_rtype(op) || (op inside {OP_ADDI, OP_LDI, OP_LD, OP_ST, OP_BR, OP_JR});
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational (state, opcode, con_ff) -> datapath strobe map; zero latency, no backpressure.
// Every strobe not named for a state stays 0, so RST, HALT and illegal states drive nothing.
module ctrl_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [3:0]        i_state,
    input  logic [4:0]        i_opc,
    input  logic              i_con_ff,
    output logic [CTRL_W-1:0] o_ctrl
);

    state_t w_state;
    ctrl_t  w_c;

    assign w_state = state_t'(i_state);
    assign o_ctrl  = w_c;

    always_comb begin
        w_c     = '0;
        w_c.run = (w_state inside {F0, F1, F2, E3, E4, E5, E6, E7});
        case (w_state)
            F0: begin w_c.pc_out = 1'b1; w_c.mar_in = 1'b1; w_c.inc_pc = 1'b1; w_c.z_in = 1'b1; end
            F1: begin w_c.zlow_out = 1'b1; w_c.pc_in = 1'b1; w_c.read = 1'b1; w_c.mdr_in = 1'b1; end
            F2: begin w_c.mdr_out = 1'b1; w_c.ir_in = 1'b1; end
            E3: begin
                if (is_rtype(i_opc) || i_opc == OP_ADDI) begin
                    w_c.grb = 1'b1; w_c.r_out = 1'b1; w_c.y_in = 1'b1;
                end else if (i_opc inside {OP_LDI, OP_LD, OP_ST}) begin
                    w_c.grb = 1'b1; w_c.ba_out = 1'b1; w_c.y_in = 1'b1;
                end else if (i_opc == OP_BR) begin
                    w_c.gra = 1'b1; w_c.r_out = 1'b1; w_c.con_in = 1'b1;
                end else if (i_opc == OP_JR) begin
                    w_c.gra = 1'b1; w_c.r_out = 1'b1; w_c.pc_in = 1'b1;
                end
            end
            E4: begin
                if (is_rtype(i_opc)) begin
                    w_c.grc     = 1'b1; w_c.r_out = 1'b1; w_c.z_in = 1'b1;
                    w_c.alu_add = (i_opc == OP_ADD);
                    w_c.alu_sub = (i_opc == OP_SUB);
                    w_c.alu_and = (i_opc == OP_AND);
                    w_c.alu_or  = (i_opc == OP_OR);
                end else if (i_opc inside {OP_ADDI, OP_LDI, OP_LD, OP_ST}) begin
                    w_c.c_out = 1'b1; w_c.alu_add = 1'b1; w_c.z_in = 1'b1;
                end else if (i_opc == OP_BR) begin
                    w_c.pc_out = 1'b1; w_c.y_in = 1'b1;
                end
            end
            E5: begin
                if (is_rtype(i_opc) || (i_opc inside {OP_ADDI, OP_LDI})) begin
                    w_c.zlow_out = 1'b1; w_c.gra = 1'b1; w_c.r_in = 1'b1;
                end else if (i_opc inside {OP_LD, OP_ST}) begin
                    w_c.zlow_out = 1'b1; w_c.mar_in = 1'b1;
                end else if (i_opc == OP_BR) begin
                    w_c.c_out = 1'b1; w_c.alu_add = 1'b1; w_c.z_in = 1'b1;
                end
            end
            E6: begin
                if (i_opc == OP_LD) begin
                    w_c.read = 1'b1; w_c.mdr_in = 1'b1;
                end else if (i_opc == OP_ST) begin
                    w_c.gra = 1'b1; w_c.r_out = 1'b1; w_c.mdr_in = 1'b1;
                end else if (i_opc == OP_BR) begin
                    // con_ff was latched by the datapath at the E3 edge, so it is valid here.
                    w_c.zlow_out = 1'b1; w_c.pc_in = i_con_ff;
                end
            end
            E7: begin
                if (i_opc == OP_LD) begin
                    w_c.mdr_out = 1'b1; w_c.gra = 1'b1; w_c.r_in = 1'b1;
                end else if (i_opc == OP_ST) begin
                    w_c.write = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit: one control state per clock, fetch -> decode -> execute -> fetch.
// Strobes are combinational from the state register (zero added latency); no stall, no backpressure.
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int IR_WIDTH = 32,
    parameter int OPC_MSB  = 31
) (
    input  logic                clk,
    input  logic                clr,
    input  logic [IR_WIDTH-1:0] ir,
    input  logic                con_ff,
    output logic read, write,
    output logic PCout, Zlowout, MDRout, Cout, BAout, Rout,
    output logic MARIn, PCIn, MDRIn, IRIn, YIn, ZIn, CONIn, RIn,
    output logic IncPC,
    output logic Gra, Grb, Grc,
    output logic add, subtract, andSignal, orSignal,
    output logic Zhighout, IN_Portout, LOout, HIout, HiIn, LoIn, CIn, InIn, OutIn, multiply, divide,
    output logic run
);

    state_t     r_state;
    logic [4:0] w_opc;
    ctrl_t      w_ctrl;
    logic       w_unused_ir;

    assign w_opc       = ir[OPC_MSB -: 5];
    assign w_unused_ir = ^ir;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= RST;
        end else begin
            case (r_state)
                RST:  r_state <= F0;
                F0:   r_state <= F1;
                F1:   r_state <= F2;
                F2: begin
                    if (w_opc == OP_HALT)     r_state <= HALT;
                    else if (has_exec(w_opc)) r_state <= E3;
                    else                      r_state <= F0;
                end
                E3:   r_state <= (w_opc == OP_JR || !has_exec(w_opc)) ? F0 : E4;
                E4:   r_state <= E5;
                E5:   r_state <= (w_opc inside {OP_LD, OP_ST, OP_BR}) ? E6 : F0;
                E6:   r_state <= (w_opc inside {OP_LD, OP_ST}) ? E7 : F0;
                E7:   r_state <= F0;
                HALT: r_state <= HALT;
                default: r_state <= F0;
            endcase
        end
    end

    ctrl_decode u_decode (
        .i_state  (r_state),
        .i_opc    (w_opc),
        .i_con_ff (con_ff),
        .o_ctrl   (w_ctrl)
    );

    assign read      = w_ctrl.read;
    assign write     = w_ctrl.write;
    assign PCout     = w_ctrl.pc_out;
    assign Zlowout   = w_ctrl.zlow_out;
    assign MDRout    = w_ctrl.mdr_out;
    assign Cout      = w_ctrl.c_out;
    assign BAout     = w_ctrl.ba_out;
    assign Rout      = w_ctrl.r_out;
    assign MARIn     = w_ctrl.mar_in;
    assign PCIn      = w_ctrl.pc_in;
    assign MDRIn     = w_ctrl.mdr_in;
    assign IRIn      = w_ctrl.ir_in;
    assign YIn       = w_ctrl.y_in;
    assign ZIn       = w_ctrl.z_in;
    assign CONIn     = w_ctrl.con_in;
    assign RIn       = w_ctrl.r_in;
    assign IncPC     = w_ctrl.inc_pc;
    assign Gra       = w_ctrl.gra;
    assign Grb       = w_ctrl.grb;
    assign Grc       = w_ctrl.grc;
    assign add       = w_ctrl.alu_add;
    assign subtract  = w_ctrl.alu_sub;
    assign andSignal = w_ctrl.alu_and;
    assign orSignal  = w_ctrl.alu_or;
    assign run       = w_ctrl.run;

    assign Zhighout   = 1'b0;
    assign IN_Portout = 1'b0;
    assign LOout      = 1'b0;
    assign HIout      = 1'b0;
    assign HiIn       = 1'b0;
    assign LoIn       = 1'b0;
    assign CIn        = 1'b0;
    assign InIn       = 1'b0;
    assign OutIn      = 1'b0;
    assign multiply   = 1'b0;
    assign divide     = 1'b0;

endmodule
